serial_tx: RTL and testbench
============================

# serial_tx

Parallel-in, serial-out bit-stream transmitter. It loads a WIDTH-bit word on a start request and emits it one bit per clock on `x`, with an optional even-parity bit. It then pulses `done`. It is the stimulus/transmit end of the single-bit serial input consumed by the board2 sequence-detector FSMs, and it drives their `x` input directly.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 2..16.
- `MSB_FIRST`, default 1: 1 sends data[WIDTH-1] first; 0 sends data[0] first.
- `PARITY`, default 0: 0 means no parity bit; 1 appends an even-parity bit (XOR of all data bits).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: frame request; sampled on the rising edge.
- `data`, input, WIDTH: word to send; captured on the edge that accepts `start`.
- `x`, output, 1: serial bit, registered.
- `x_valid`, output, 1: high while `x` carries a data or parity bit.
- `busy`, output, 1: high in SHIFT and PAR.
- `done`, output, 1: one-cycle pulse after the last bit.

## Operation
- States, encoded in 2 bits:
  - IDLE=00
  - SHIFT=01
  - PAR=10
  - DONE=11
- Reset (async, immediate):
  - state=IDLE; shift register=0; bit counter=0.
  - `x`=0, `x_valid`=0, `busy`=0, `done`=0.
- Transitions:
  - IDLE: `start`=1 → SHIFT. `data` is loaded into the shift register and the counter is set to WIDTH-1.
  - SHIFT: each cycle presents the current head bit on `x`, shifts toward the head, and decrements the counter. When the counter reaches 0, go to PAR if PARITY=1, else DONE.
  - PAR: presents the parity computed at load time, then → DONE.
  - DONE: `done`=1 for this cycle.
    - `start`=1 here → SHIFT with a new load (back-to-back frames, no idle gap).
    - Otherwise → IDLE.
- Start acceptance:
  - `start` is accepted only in IDLE and DONE.
  - `start` during SHIFT/PAR is ignored, not queued.
  - `data` changes after acceptance have no effect on the frame in flight.
- Outside SHIFT/PAR, `x` is driven to 0 and `x_valid`=0.
- Counter width is $clog2(WIDTH). The counter counts down only; it never wraps inside a frame.
- Parity is computed once from `data` at load (reduction XOR), not from the shifting register.

## Timing
- Latency: `start` accepted on edge E0; first bit appears on `x` after E0 and is stable until E1. Bit k is on `x` between E(k) and E(k+1).
- Frame length (start edge to `done` pulse edge):
  - WIDTH cycles of data.
  - +1 cycle of parity when PARITY=1.
  - `done` is high for exactly 1 cycle.
- `busy` is high for WIDTH (+1) cycles and is low in the DONE cycle.
- Back-to-back frame period is WIDTH+1 cycles (WIDTH+2 with parity).
- Reset asserted mid-frame aborts the frame:
  - all outputs go to 0 at once, with no `done` pulse.
  - After deassertion, the block sits in IDLE until a new `start`.
- `start` coincident with reset release: it is honoured on the first rising edge where `rst`=0.

## Structure
- Shared package `serial_pkg`:
  - state encodings ST_IDLE, ST_SHIFT, ST_PAR, ST_DONE.
  - parity mode constants PAR_NONE=0, PAR_EVEN=1.
- One sub-module: `piso_shreg`.
  - Ports: clk, rst, load, shift, din[WIDTH], dout (head bit); parameters WIDTH, MSB_FIRST.
  - Holds the word and performs the shifts.
- `serial_tx` owns the FSM, bit counter, parity register and output registers.

## Test plan
- **Reset:** `rst` pulsed mid-run → `x`=0, `x_valid`=0, `busy`=0, `done`=0 immediately, asynchronously of `clk`.
- **Basic frame, MSB first:** WIDTH=8, MSB_FIRST=1, PARITY=0, data=8'b1011_0010, `start` 1 cycle → `x` sequence 1,0,1,1,0,0,1,0 on cycles 1–8; `done`=1 on cycle 9; `busy`=0 from cycle 9.
- **LSB first with parity:** MSB_FIRST=0, PARITY=1, data=8'hA7 → `x` = 1,1,1,0,0,1,0,1, then parity bit 1 (five ones) on cycle 9; `done` on cycle 10.
- **Back-to-back:** `start` held high with data=8'hFF, then 8'h00 presented in the DONE cycle → eight 1s, `done`, then eight 0s starting the next cycle, with no idle gap.
- **Ignored start:** `start` pulsed with data=8'h55 at cycle 4 of a frame sending 8'hF0 → the frame completes as 8'hF0; no second frame; IDLE after `done`.
- **Reset mid-frame:** `rst` at cycle 3 of a frame → no `done` pulse; a new `start` after release sends a full, correct frame.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM encodings and parity modes.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;

endpackage

// File: rtl/serial_tx_piso_shreg.sv
// Parallel-in serial-out shift register; dout is the current head bit.
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = din;
    end else if (shift) begin
      if (MSB_FIRST != 0) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      else                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

  assign dout = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/serial_tx.sv
// Serial bit-stream transmitter: loads a word on start, shifts it out on x one
// bit per clock with optional even parity, then pulses done.
//
// state | meaning
// IDLE  | waiting for start, outputs low
// SHIFT | data bits on x, counter counts remaining bits
// PAR   | parity bit on x
// DONE  | one-cycle done pulse; start here begins the next frame
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = PAR_NONE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            par_q, par_d;
  logic            x_q, x_d;
  logic            x_valid_q, x_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic             load, shift, shreg_dout, data_head;
  logic [WIDTH-1:0] din_adv;

  // The head bit goes straight into x_q on the load edge, so the shift
  // register is loaded one position advanced; its dout is then the next bit.
  always_comb begin
    if (MSB_FIRST != 0) begin
      data_head = data[WIDTH-1];
      din_adv   = {data[WIDTH-2:0], 1'b0};
    end else begin
      data_head = data[0];
      din_adv   = {1'b0, data[WIDTH-1:1]};
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (din_adv),
    .dout  (shreg_dout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    load      = 1'b0;
    shift     = 1'b0;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_d   = ST_SHIFT;
          cnt_d     = CNT_INIT;
          par_d     = ^data;
          x_d       = data_head;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          shift     = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          x_d       = shreg_dout;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (PARITY == PAR_EVEN) begin
          state_d   = ST_PAR;
          x_d       = par_q;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_PAR: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one MSB-first/no-parity and one
// LSB-first/even-parity instance, outputs checked as {x, x_valid, busy, done}.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_m, start_l;
  logic [7:0] data_m, data_l;
  logic       x_m, xv_m, busy_m, done_m;
  logic       x_l, xv_l, busy_l, done_l;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0)) u_msb (
    .clk     (clk),
    .rst     (rst),
    .start   (start_m),
    .data    (data_m),
    .x       (x_m),
    .x_valid (xv_m),
    .busy    (busy_m),
    .done    (done_m)
  );

  serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY(1)) u_lsb (
    .clk     (clk),
    .rst     (rst),
    .start   (start_l),
    .data    (data_l),
    .x       (x_l),
    .x_valid (xv_l),
    .busy    (busy_l),
    .done    (done_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] seq;

    rst = 1'b1; start_m = 1'b0; start_l = 1'b0; data_m = '0; data_l = '0;
    #2;
    chk("reset_msb", {x_m, xv_m, busy_m, done_m}, 4'b0000);
    chk("reset_lsb", {x_l, xv_l, busy_l, done_l}, 4'b0000);
    step();
    rst = 1'b0;
    step();
    chk("idle_msb", {x_m, xv_m, busy_m, done_m}, 4'b0000);

    // basic MSB-first frame, 8'b1011_0010
    seq = 8'b1011_0010;
    data_m = 8'b1011_0010; start_m = 1'b1;
    step();
    start_m = 1'b0; data_m = 8'h00;
    chk("basic_bit0", {x_m, xv_m, busy_m, done_m}, {seq[7], 3'b110});
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("basic_bit%0d", k), {x_m, xv_m, busy_m, done_m}, {seq[7-k], 3'b110});
    end
    step();
    chk("basic_done", {x_m, xv_m, busy_m, done_m}, 4'b0001);
    step();
    chk("basic_idle", {x_m, xv_m, busy_m, done_m}, 4'b0000);

    // LSB-first with parity, 8'hA7: transmit order 1,1,1,0,0,1,0,1 then parity 1
    seq = 8'b1110_0101;
    data_l = 8'hA7; start_l = 1'b1;
    step();
    start_l = 1'b0; data_l = 8'h00;
    chk("lsb_bit0", {x_l, xv_l, busy_l, done_l}, {seq[7], 3'b110});
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("lsb_bit%0d", k), {x_l, xv_l, busy_l, done_l}, {seq[7-k], 3'b110});
    end
    step();
    chk("lsb_parity", {x_l, xv_l, busy_l, done_l}, 4'b1110);
    step();
    chk("lsb_done", {x_l, xv_l, busy_l, done_l}, 4'b0001);
    step();
    chk("lsb_idle", {x_l, xv_l, busy_l, done_l}, 4'b0000);

    // back-to-back: 8'hFF then 8'h00 presented in the DONE cycle
    data_m = 8'hFF; start_m = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("b2b_ff_bit%0d", k), {x_m, xv_m, busy_m, done_m}, 4'b1110);
    end
    step();
    chk("b2b_done1", {x_m, xv_m, busy_m, done_m}, 4'b0001);
    data_m = 8'h00;
    step();
    start_m = 1'b0;
    chk("b2b_00_bit0", {x_m, xv_m, busy_m, done_m}, 4'b0110);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("b2b_00_bit%0d", k), {x_m, xv_m, busy_m, done_m}, 4'b0110);
    end
    step();
    chk("b2b_done2", {x_m, xv_m, busy_m, done_m}, 4'b0001);
    step();
    chk("b2b_idle", {x_m, xv_m, busy_m, done_m}, 4'b0000);

    // start with 8'h55 during cycle 4 of an 8'hF0 frame is ignored
    seq = 8'hF0;
    data_m = 8'hF0; start_m = 1'b1;
    step();
    start_m = 1'b0;
    chk("ign_bit0", {x_m, xv_m, busy_m, done_m}, {seq[7], 3'b110});
    for (int k = 1; k < 8; k++) begin
      if (k == 3) begin
        data_m = 8'h55; start_m = 1'b1;
      end else begin
        start_m = 1'b0;
      end
      step();
      chk($sformatf("ign_bit%0d", k), {x_m, xv_m, busy_m, done_m}, {seq[7-k], 3'b110});
    end
    start_m = 1'b0;
    step();
    chk("ign_done", {x_m, xv_m, busy_m, done_m}, 4'b0001);
    step();
    chk("ign_idle1", {x_m, xv_m, busy_m, done_m}, 4'b0000);
    step();
    chk("ign_idle2", {x_m, xv_m, busy_m, done_m}, 4'b0000);

    // reset mid-frame, then a fresh 8'h5A frame
    data_m = 8'hC3; start_m = 1'b1;
    step();
    start_m = 1'b0;
    step();
    step();
    chk("rst_pre", {x_m, xv_m, busy_m, done_m}, 4'b0110);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {x_m, xv_m, busy_m, done_m}, 4'b0000);
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("rst_nodone%0d", k), {x_m, xv_m, busy_m, done_m}, 4'b0000);
    end
    seq = 8'h5A;
    data_m = 8'h5A; start_m = 1'b1;
    step();
    start_m = 1'b0;
    chk("post_bit0", {x_m, xv_m, busy_m, done_m}, {seq[7], 3'b110});
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("post_bit%0d", k), {x_m, xv_m, busy_m, done_m}, {seq[7-k], 3'b110});
    end
    step();
    chk("post_done", {x_m, xv_m, busy_m, done_m}, 4'b0001);
    step();
    chk("post_idle", {x_m, xv_m, busy_m, done_m}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
